// File: rtl/branch_predictor.sv
// ---------------------------------------------------------------------------
// branch_predictor
//   IF-stage dynamic branch predictor: a direct-mapped BTB where every entry
//   holds valid, tag, target and a 2-bit saturating direction counter.
//
//   Lookup is purely combinational from IF_pc. Training happens at the clock
//   edge from the EXE-stage resolution.
//
//   Optional feature macro: BP_STATS_EN
//     When defined, adds the Flush input and the stat_lookups/stat_misses
//     counters. When undefined, those ports and counters do not exist.
//
// Ports
//   clk, rst        clock; asynchronous active-high reset
//   IF_pc           IF-stage PC used for the lookup
//   BP_taken        predicted taken (hit and counter MSB set)
//   BP_target_pc    predicted target on a hit, otherwise 0
//   E_En            EXE holds a branch/jump, i.e. a train request
//   E_pc            PC of the EXE instruction
//   E_Branch_taken  resolved direction
//   E_target_pc     resolved target
//   Stall_MA        memory stall; blocks training
//   Flush           mispredict flush                  (BP_STATS_EN)
//   stat_lookups    number of trained branches        (BP_STATS_EN)
//   stat_misses     number of mispredicts             (BP_STATS_EN)
//
// Train qualifier: there is no ready path back to EXE. A train request is
// accepted at the rising edge of clk exactly when E_En=1 and Stall_MA=0.
// Stall_MA holds the same EXE instruction in place, so blocking the train
// while it is high keeps that instruction from being counted twice.
// ---------------------------------------------------------------------------
module branch_predictor #(
    parameter int memAddrWidth = 15,
    parameter int ENTRIES      = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [memAddrWidth-1:0] IF_pc,
    output logic                    BP_taken,
    output logic [memAddrWidth-1:0] BP_target_pc,
    input  logic                    E_En,
    input  logic [memAddrWidth-1:0] E_pc,
    input  logic                    E_Branch_taken,
    input  logic [memAddrWidth-1:0] E_target_pc,
    input  logic                    Stall_MA
`ifdef BP_STATS_EN
    ,
    input  logic                    Flush,
    output logic [31:0]             stat_lookups,
    output logic [31:0]             stat_misses
`endif
);

    localparam int IDXW = $clog2(ENTRIES);
    localparam int TAGW = memAddrWidth - IDXW - 2;

    // BTB storage
    logic                    valid_q  [ENTRIES];
    logic [TAGW-1:0]         tag_q    [ENTRIES];
    logic [memAddrWidth-1:0] target_q [ENTRIES];
    logic [1:0]              cnt_q    [ENTRIES];

    // Instructions are word aligned, so PC bits [1:0] never take part
    // in the index or the tag.
    logic unused_pc_lsbs;
    assign unused_pc_lsbs = &{1'b0, IF_pc[1:0], E_pc[1:0]};

    logic [IDXW-1:0] if_idx;
    logic [TAGW-1:0] if_tag;
    logic [IDXW-1:0] e_idx;
    logic [TAGW-1:0] e_tag;

    assign if_idx = IF_pc[IDXW+1:2];
    assign if_tag = IF_pc[memAddrWidth-1:IDXW+2];
    assign e_idx  = E_pc[IDXW+1:2];
    assign e_tag  = E_pc[memAddrWidth-1:IDXW+2];

    // Lookup. There is no bypass from a training write in the same cycle:
    // the stored entry only changes at the clock edge.
    logic if_hit;

    always_comb begin
        if_hit       = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
        BP_taken     = if_hit & cnt_q[if_idx][1];
        BP_target_pc = if_hit ? target_q[if_idx] : '0;
    end

    // Train-side decode
    logic       train_en;
    logic       e_hit;
    logic [1:0] e_cnt;
    logic [1:0] cnt_inc;
    logic [1:0] cnt_dec;

    always_comb begin
        train_en = E_En & ~Stall_MA;
        e_hit    = valid_q[e_idx] && (tag_q[e_idx] == e_tag);
        e_cnt    = cnt_q[e_idx];
        cnt_inc  = (e_cnt == 2'b11) ? 2'b11 : e_cnt + 2'd1;
        cnt_dec  = (e_cnt == 2'b00) ? 2'b00 : e_cnt - 2'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                cnt_q[i]    <= 2'b01;
            end
        end else if (train_en) begin
            if (e_hit) begin
                if (E_Branch_taken) begin
                    cnt_q[e_idx]    <= cnt_inc;
                    target_q[e_idx] <= E_target_pc;
                end else begin
                    // A not-taken resolution keeps the last taken target.
                    cnt_q[e_idx] <= cnt_dec;
                end
            end else begin
                // A miss allocates or replaces the entry. The counter starts
                // in the weak state that matches the first outcome.
                valid_q[e_idx]  <= 1'b1;
                tag_q[e_idx]    <= e_tag;
                target_q[e_idx] <= E_target_pc;
                cnt_q[e_idx]    <= E_Branch_taken ? 2'b10 : 2'b01;
            end
        end
    end

`ifdef BP_STATS_EN
    // Saturating event counters. A flush marks the trained branch as
    // mispredicted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_lookups <= '0;
            stat_misses  <= '0;
        end else if (train_en) begin
            if (stat_lookups != 32'hFFFF_FFFF) begin
                stat_lookups <= stat_lookups + 32'd1;
            end
            if (Flush && (stat_misses != 32'hFFFF_FFFF)) begin
                stat_misses <= stat_misses + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// ---------------------------------------------------------------------------
// tb_branch_predictor
//   Self-checking bench for branch_predictor (memAddrWidth=15, ENTRIES=16).
//   It runs directed scenarios and then randomized traffic. A behavioural BTB
//   model with a plain array per field and integer counters supplies every
//   expected value. Stats checks are present only when BP_STATS_EN is defined.
// ---------------------------------------------------------------------------
module tb_branch_predictor;

    logic        clk;
    logic        rst;
    logic [14:0] IF_pc;
    logic        BP_taken;
    logic [14:0] BP_target_pc;
    logic        E_En;
    logic [14:0] E_pc;
    logic        E_Branch_taken;
    logic [14:0] E_target_pc;
    logic        Stall_MA;
    logic        Flush;
`ifdef BP_STATS_EN
    logic [31:0] stat_lookups;
    logic [31:0] stat_misses;
`endif

    int total = 0;
    int bad   = 0;

    branch_predictor #(.memAddrWidth(15), .ENTRIES(16)) dut (
        .clk            (clk),
        .rst            (rst),
        .IF_pc          (IF_pc),
        .BP_taken       (BP_taken),
        .BP_target_pc   (BP_target_pc),
        .E_En           (E_En),
        .E_pc           (E_pc),
        .E_Branch_taken (E_Branch_taken),
        .E_target_pc    (E_target_pc),
        .Stall_MA       (Stall_MA)
`ifdef BP_STATS_EN
        ,
        .Flush          (Flush),
        .stat_lookups   (stat_lookups),
        .stat_misses    (stat_misses)
`endif
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // The index is word number modulo 16 and the tag is the word number
    // divided by 16. Counters are integers 0..3, and "taken" means >= 2.
    bit m_valid  [16];
    int m_tag    [16];
    int m_target [16];
    int m_cnt    [16];
    int m_lookups;
    int m_misses;

    function automatic void m_reset();
        for (int i = 0; i < 16; i++) begin
            m_valid[i]  = 1'b0;
            m_tag[i]    = 0;
            m_target[i] = 0;
            m_cnt[i]    = 1;
        end
        m_lookups = 0;
        m_misses  = 0;
    endfunction

    function automatic int m_idx(int pc);
        return (pc / 4) % 16;
    endfunction

    function automatic int m_tg(int pc);
        return pc / 64;
    endfunction

    function automatic bit m_hit(int pc);
        return m_valid[m_idx(pc)] && (m_tag[m_idx(pc)] == m_tg(pc));
    endfunction

    function automatic void m_train(int pc, bit tk, int tgt, bit fl);
        int i;
        i = m_idx(pc);
        if (m_hit(pc)) begin
            if (tk) begin
                m_cnt[i]    = (m_cnt[i] + 1 > 3) ? 3 : m_cnt[i] + 1;
                m_target[i] = tgt;
            end else begin
                m_cnt[i] = (m_cnt[i] - 1 < 0) ? 0 : m_cnt[i] - 1;
            end
        end else begin
            m_valid[i]  = 1'b1;
            m_tag[i]    = m_tg(pc);
            m_target[i] = tgt;
            m_cnt[i]    = tk ? 2 : 1;
        end
        m_lookups++;
        if (fl) m_misses++;
    endfunction

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_lookup(input string tag);
        bit h;
        int e_tk;
        int e_tg;
        h    = m_hit(int'(IF_pc));
        e_tk = (h && m_cnt[m_idx(int'(IF_pc))] >= 2) ? 1 : 0;
        e_tg = h ? m_target[m_idx(int'(IF_pc))] : 0;
        check({tag, "_taken"}, {31'd0, BP_taken}, e_tk);
        check({tag, "_target"}, {17'd0, BP_target_pc}, e_tg);
`ifdef BP_STATS_EN
        check({tag, "_stat_lookups"}, stat_lookups, m_lookups);
        check({tag, "_stat_misses"}, stat_misses, m_misses);
`endif
    endtask

    // ---------------- driver ----------------
    // One clock: apply the inputs, check the combinational lookup on the
    // falling edge (pre-update state), then advance the model past the
    // rising edge.
    task automatic cycle(input string tag, input int ifpc, input bit en, input int epc,
                         input bit tk, input int tgt, input bit stall, input bit fl);
        IF_pc          = 15'(ifpc);
        E_En           = en;
        E_pc           = 15'(epc);
        E_Branch_taken = tk;
        E_target_pc    = 15'(tgt);
        Stall_MA       = stall;
        Flush          = fl;
        @(negedge clk);
        check_lookup(tag);
        @(posedge clk);
        if (en && !stall) m_train(epc, tk, tgt, fl);
        #1;
    endtask

    task automatic idle_lookup(input string tag, input int ifpc);
        cycle(tag, ifpc, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int pcs [8];

        rst = 1'b1;
        IF_pc = 15'h0040; E_En = 0; E_pc = 0; E_Branch_taken = 0;
        E_target_pc = 0; Stall_MA = 0; Flush = 0;
        m_reset();
        @(negedge clk);
        check("reset_taken", {31'd0, BP_taken}, 0);
        check("reset_target", {17'd0, BP_target_pc}, 0);
        @(posedge clk);
        #1 rst = 1'b0;

        // One taken train, then a lookup on the next cycle.
        cycle("t2_train", 'h0040, 1, 'h0040, 1, 'h0100, 0, 0);
        idle_lookup("t2_look", 'h0040);
        check("t2_const_taken", {31'd0, BP_taken}, 1);
        check("t2_const_target", {17'd0, BP_target_pc}, 'h0100);

        // Two not-taken trains: 10 -> 01 -> 00, and the target is kept.
        cycle("t3_nt1", 'h0040, 1, 'h0040, 0, 'h0555, 0, 0);
        idle_lookup("t3_look1", 'h0040);
        check("t3_const_taken", {31'd0, BP_taken}, 0);
        check("t3_const_target", {17'd0, BP_target_pc}, 'h0100);
        cycle("t3_nt2", 'h0040, 1, 'h0040, 0, 'h0555, 0, 0);
        idle_lookup("t3_look2", 'h0040);

        // Alias on idx 0 with a new tag.
        cycle("t4_alias", 'h0080, 1, 'h0080, 1, 'h0200, 0, 0);
        idle_lookup("t4_old", 'h0040);
        idle_lookup("t4_new", 'h0082);

        // Training is blocked for three stalled cycles.
        for (int i = 0; i < 3; i++)
            cycle("t5_stall", 'h0080, 1, 'h0080, 0, 'h0777, 1, 0);
        idle_lookup("t5_after_stall", 'h0080);

        // Same-cycle train and lookup of one idx: old value, new one next cycle.
        cycle("t5_same", 'h0040, 1, 'h0040, 1, 'h0300, 0, 0);
        idle_lookup("t5_next", 'h0040);

        // Saturation at both ends.
        for (int i = 0; i < 4; i++) cycle("sat_up", 'h0044, 1, 'h0044, 1, 'h0010 + i, 0, 0);
        for (int i = 0; i < 5; i++) cycle("sat_dn", 'h0044, 1, 'h0044, 0, 0, 0, 0);
        idle_lookup("sat_end", 'h0044);

        // Randomized traffic over a small set of PCs, chosen so that hits,
        // aliases and same-idx cases are frequent.
        for (int i = 0; i < 8; i++)
            pcs[i] = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 3) << 2);
        for (int n = 0; n < 400; n++) begin
            int ep;
            ep = pcs[$urandom_range(0, 7)] | $urandom_range(0, 3);
            cycle("rand",
                  ($urandom_range(0, 3) == 0) ? ep : (pcs[$urandom_range(0, 7)] | $urandom_range(0, 3)),
                  ($urandom_range(0, 9) < 7), ep, ($urandom_range(0, 9) < 6),
                  $urandom_range(0, 32767), ($urandom_range(0, 9) < 2), ($urandom_range(0, 4) == 0));
        end

        // Asynchronous reset mid-run, asserted away from any clock edge.
        IF_pc = 15'(pcs[0]); E_En = 0; Stall_MA = 0; Flush = 0;
        cycle("pre_rst", pcs[0], 1, pcs[0], 1, 'h0123, 0, 0);
        rst = 1'b1;
        m_reset();
        #1;
        check("rst_async_taken", {31'd0, BP_taken}, 0);
        check("rst_async_target", {17'd0, BP_target_pc}, 0);
`ifdef BP_STATS_EN
        check("rst_async_lookups", stat_lookups, 0);
        check("rst_async_misses", stat_misses, 0);
`endif
        @(posedge clk);
        #3 rst = 1'b0;
        for (int i = 0; i < 8; i++) idle_lookup("post_rst", pcs[i]);

        // Five trains, two of them in a flush cycle.
        cycle("st1", 'h0000, 1, 'h0010, 1, 'h0020, 0, 0);
        cycle("st2", 'h0000, 1, 'h0014, 0, 'h0020, 0, 1);
        cycle("st3", 'h0000, 1, 'h0018, 1, 'h0020, 0, 0);
        cycle("st4", 'h0000, 1, 'h0010, 0, 'h0020, 0, 1);
        cycle("st5", 'h0000, 1, 'h001C, 1, 'h0020, 0, 0);
        idle_lookup("st_end", 'h0010);
`ifdef BP_STATS_EN
        check("st_const_lookups", stat_lookups, 5);
        check("st_const_misses", stat_misses, 2);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
